// File: rtl/sd_pkg.sv
// Shared definitions for the SD write path (sd_block_writer and card_driver).
// Sector size, byte/address widths and the block-writer FSM encoding.
package sd_pkg;
  localparam int SD_BLOCK_BYTES = 512;
  localparam int SD_BYTE_W      = 8;
  localparam int SD_ADDR_W      = 32;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_PAD,
    ST_CMD,
    ST_DATA_RD,
    ST_DATA,
    ST_DONE
  } sdw_state_e;
endpackage

// File: rtl/sdw_sector_ram.sv
// Simple dual-port sector buffer: one write port, one registered read port.
module sdw_sector_ram #(
  parameter  int DEPTH = 512,
  parameter  int DW    = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/sd_block_writer.sv
// Packs a producer byte stream into sectors and writes them via card_driver.
// SDW_PINGPONG_EN: two sector buffers so filling overlaps the card transfer.
module sd_block_writer
  import sd_pkg::*;
#(
  parameter int                   BLOCK_BYTES = SD_BLOCK_BYTES,
  parameter logic [SD_ADDR_W-1:0] START_BLOCK = 32'd0,
  parameter logic [SD_BYTE_W-1:0] PAD_BYTE    = 8'h00
) (
  input  logic                 CLOCK50,
  input  logic                 RESET,
  input  logic                 IN_VALID,
  input  logic [SD_BYTE_W-1:0] IN_DATA,
  output logic                 IN_READY,
  input  logic                 FLUSH,
  output logic                 WR_STB,
  output logic [SD_ADDR_W-1:0] WR_ADDR,
  input  logic                 WR_ACK,
  output logic                 WD_STB,
  output logic [SD_BYTE_W-1:0] WD_DATA,
  input  logic                 WD_ACK,
  output logic                 BUSY,
  output logic                 BLK_DONE,
  output logic [SD_ADDR_W-1:0] BLK_CNT
);
`ifdef SDW_PINGPONG_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif
  localparam int AW  = $clog2(BLOCK_BYTES);
  localparam int RAW = $clog2(NBUF * BLOCK_BYTES);
  localparam logic [AW-1:0] LAST = AW'(BLOCK_BYTES - 1);

  // Fill side (FILL/PAD) and drain side (CMD..DONE) run as separate FSMs;
  // the drain side parks in ST_FILL while waiting for a full buffer.
  sdw_state_e fstate_q, fstate_d, dstate_q, dstate_d;
  logic [AW-1:0]        wp_q, wp_d, rp_q, rp_d;
  logic                 fb_q, fb_d, db_q, db_d;
  logic [1:0]           full_q, full_d;
  logic                 in_ready_q, in_ready_d;
  logic [SD_ADDR_W-1:0] wr_addr_q, wr_addr_d, blk_cnt_q, blk_cnt_d;

  logic                 full_set, full_clr, ram_we, ram_re;
  logic [SD_BYTE_W-1:0] ram_wdata, ram_rdata;

  always_comb begin
    fstate_d  = fstate_q;
    wp_d      = wp_q;
    fb_d      = fb_q;
    full_set  = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = IN_DATA;
    case (fstate_q)
      ST_FILL: if (in_ready_q) begin
        if (IN_VALID) begin
          ram_we = 1'b1;
          wp_d   = wp_q + AW'(1);
          if (wp_q == LAST) full_set = 1'b1;
          else if (FLUSH)   fstate_d = ST_PAD;
        end else if (FLUSH && wp_q != '0) begin
          fstate_d = ST_PAD;
        end
      end
      ST_PAD: begin
        ram_we    = 1'b1;
        ram_wdata = PAD_BYTE;
        wp_d      = wp_q + AW'(1);
        if (wp_q == LAST) begin
          full_set = 1'b1;
          fstate_d = ST_FILL;
        end
      end
      default: fstate_d = ST_FILL;
    endcase
    if (full_set && NBUF == 2) fb_d = ~fb_q;
  end

  always_comb begin
    dstate_d  = dstate_q;
    rp_d      = rp_q;
    db_d      = db_q;
    full_clr  = 1'b0;
    ram_re    = 1'b0;
    wr_addr_d = wr_addr_q;
    blk_cnt_d = blk_cnt_q;
    case (dstate_q)
      // A buffer completing this cycle starts its command on the next one.
      ST_FILL:    if (full_q[db_q] || (full_set && fb_q == db_q)) dstate_d = ST_CMD;
      ST_CMD:     if (WR_ACK) dstate_d = ST_DATA_RD;
      ST_DATA_RD: begin
        ram_re   = 1'b1;
        dstate_d = ST_DATA;
      end
      ST_DATA: if (WD_ACK) begin
        rp_d     = rp_q + AW'(1);
        dstate_d = (rp_q == LAST) ? ST_DONE : ST_DATA_RD;
      end
      ST_DONE: begin
        full_clr  = 1'b1;
        wr_addr_d = wr_addr_q + 32'd1;
        blk_cnt_d = blk_cnt_q + 32'd1;
        if (NBUF == 2) db_d = ~db_q;
        dstate_d  = ST_FILL;
      end
      default: dstate_d = ST_FILL;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (full_set) full_d[fb_q] = 1'b1;
    if (full_clr) full_d[db_q] = 1'b0;
    in_ready_d = (fstate_d == ST_FILL) && !full_d[fb_d];
  end

  always_ff @(posedge CLOCK50 or negedge RESET) begin
    if (!RESET) begin
      fstate_q   <= ST_FILL;
      dstate_q   <= ST_FILL;
      wp_q       <= '0;
      rp_q       <= '0;
      fb_q       <= 1'b0;
      db_q       <= 1'b0;
      full_q     <= '0;
      in_ready_q <= 1'b0;
      wr_addr_q  <= START_BLOCK;
      blk_cnt_q  <= '0;
    end else begin
      fstate_q   <= fstate_d;
      dstate_q   <= dstate_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      fb_q       <= fb_d;
      db_q       <= db_d;
      full_q     <= full_d;
      in_ready_q <= in_ready_d;
      wr_addr_q  <= wr_addr_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

  sdw_sector_ram #(.DEPTH(NBUF * BLOCK_BYTES), .DW(SD_BYTE_W)) u_ram (
    .clk   (CLOCK50),
    .we    (ram_we),
    .waddr (RAW'({fb_q, wp_q})),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (RAW'({db_q, rp_q})),
    .rdata (ram_rdata)
  );

  assign IN_READY = in_ready_q;
  assign WR_STB   = (dstate_q == ST_CMD);
  assign WR_ADDR  = wr_addr_q;
  assign WD_STB   = (dstate_q == ST_DATA);
  assign WD_DATA  = WD_STB ? ram_rdata : '0;
  assign BUSY     = (dstate_q == ST_CMD) || (dstate_q == ST_DATA_RD) || (dstate_q == ST_DATA);
  assign BLK_DONE = (dstate_q == ST_DONE);
  assign BLK_CNT  = blk_cnt_q;
endmodule

// File: tb/tb_sd_block_writer.sv
// Directed bench for sd_block_writer with a small card_driver ack model.
// A second instance with START_BLOCK=FFFFFFFF shares all inputs to check address wrap.
module tb_sd_block_writer;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, wr_ack, wd_ack;
  logic [7:0]  in_data;
  logic        in_ready, wr_stb, wd_stb, busy, blk_done;
  logic [31:0] wr_addr, blk_cnt;
  logic [7:0]  wd_data;
  logic        w_in_ready, w_wr_stb, w_wd_stb, w_busy, w_blk_done;
  logic [31:0] w_wr_addr, w_blk_cnt;
  logic [7:0]  w_wd_data;

  int total = 0;
  int bad   = 0;
  int wr_dly = 3, wd_dly = 2;
  int wr_cnt = 0, wd_cnt = 0;
  int done_cnt = 0, rdy_busy_cnt = 0, diff_cnt = 0, stall_cnt = 0;
  logic [31:0] wrq[$];
  logic [31:0] wwrq[$];
  logic [7:0]  wdq[$];

  always #5 clk = ~clk;

  sd_block_writer #(.START_BLOCK(32'd0), .PAD_BYTE(8'h00)) dut (
    .CLOCK50(clk), .RESET(rst_n), .IN_VALID(in_valid), .IN_DATA(in_data), .IN_READY(in_ready),
    .FLUSH(flush), .WR_STB(wr_stb), .WR_ADDR(wr_addr), .WR_ACK(wr_ack), .WD_STB(wd_stb),
    .WD_DATA(wd_data), .WD_ACK(wd_ack), .BUSY(busy), .BLK_DONE(blk_done), .BLK_CNT(blk_cnt));

  sd_block_writer #(.START_BLOCK(32'hFFFF_FFFF), .PAD_BYTE(8'h00)) dut_w (
    .CLOCK50(clk), .RESET(rst_n), .IN_VALID(in_valid), .IN_DATA(in_data), .IN_READY(w_in_ready),
    .FLUSH(flush), .WR_STB(w_wr_stb), .WR_ADDR(w_wr_addr), .WR_ACK(wr_ack), .WD_STB(w_wd_stb),
    .WD_DATA(w_wd_data), .WD_ACK(wd_ack), .BUSY(w_busy), .BLK_DONE(w_blk_done), .BLK_CNT(w_blk_cnt));

  // Card model: ack the command after wr_dly cycles of WR_STB, each byte after wd_dly cycles.
  initial begin
    wr_ack = 1'b0;
    wd_ack = 1'b0;
    forever begin
      @(negedge clk);
      wr_ack = 1'b0;
      wd_ack = 1'b0;
      if (wr_stb) begin
        wr_cnt++;
        if (wr_cnt == wr_dly) begin
          wr_ack = 1'b1; wr_cnt = 0; wrq.push_back(wr_addr); wwrq.push_back(w_wr_addr);
        end
      end else wr_cnt = 0;
      if (wd_stb) begin
        wd_cnt++;
        if (wd_cnt == wd_dly) begin
          wd_ack = 1'b1; wd_cnt = 0; wdq.push_back(wd_data);
        end
      end else wd_cnt = 0;
      if (blk_done) done_cnt++;
      if (in_ready && busy) rdy_busy_cnt++;
      if ({in_ready, wr_stb, wd_stb, busy, blk_done, wd_data, blk_cnt} !==
          {w_in_ready, w_wr_stb, w_wd_stb, w_busy, w_blk_done, w_wd_data, w_blk_cnt}) diff_cnt++;
    end
  end

  task automatic clr_mon();
    wrq.delete(); wwrq.delete(); wdq.delete();
    done_cnt = 0; rdy_busy_cnt = 0; stall_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr_mon();
  endtask

  task automatic push_bytes(input int n, input bit inc, input logic [7:0] val);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!in_ready && t < 20000) begin @(negedge clk); t++; stall_cnt++; end
      if (!in_ready) begin
        total++; bad++;
        $display("FAIL push_timeout byte %0d: in_ready=%b required 1", i, in_ready);
        return;
      end
      in_valid = 1'b1;
      in_data  = inc ? i[7:0] : val;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_blk(input int target, input string name);
    int t = 0;
    while (blk_cnt < 32'(target) && t < 30000) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    total++;
    if (blk_cnt !== 32'(target)) begin
      bad++; $display("FAIL %s blk_cnt: got %0d required %0d", name, blk_cnt, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, wr_stb, wd_stb, busy, blk_done} !== 5'b0 || wr_addr !== 32'd0 ||
        wd_data !== 8'h00 || blk_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_outputs: rdy=%b wr=%b wd=%b busy=%b done=%b addr=%h data=%h cnt=%0d required all 0",
                      in_ready, wr_stb, wd_stb, busy, blk_done, wr_addr, wd_data, blk_cnt);
    end
    total++;
    if (w_wr_addr !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL reset_start_block: got %h required ffffffff", w_wr_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_full_sector();
    int nerr = 0;
    do_reset();
    wr_dly = 3; wd_dly = 2;
    push_bytes(512, 1'b1, 8'h00);
    wait_blk(1, "full_sector");
    total++;
    if (wrq.size() !== 1 || wrq[0] !== 32'd0) begin
      bad++; $display("FAIL full_sector_cmd: %0d cmds first=%h required 1 cmd at 00000000", wrq.size(), wrq[0]);
    end
    if (wdq.size() != 512) nerr++;
    else for (int i = 0; i < 512; i++) if (wdq[i] !== 8'(i)) nerr++;
    total++;
    if (nerr != 0) begin bad++; $display("FAIL full_sector_data: %0d bad of %0d bytes, required 0 bad of 512", nerr, wdq.size()); end
    total++;
    if (done_cnt != 1 || wr_addr !== 32'd1 || busy !== 1'b0) begin
      bad++; $display("FAIL full_sector_end: done=%0d addr=%h busy=%b required 1/00000001/0", done_cnt, wr_addr, busy);
    end
`ifndef SDW_PINGPONG_EN
    total++;
    if (rdy_busy_cnt != 0) begin bad++; $display("FAIL single_buf_stall: ready during busy %0d cycles, required 0", rdy_busy_cnt); end
`endif
  endtask

  task automatic test_flush_partial();
    int nerr = 0;
    do_reset();
    push_bytes(100, 1'b0, 8'hA5);
    pulse_flush();
    wait_blk(1, "flush_partial");
    if (wdq.size() != 512) nerr++;
    else for (int i = 0; i < 512; i++) if (wdq[i] !== ((i < 100) ? 8'hA5 : 8'h00)) nerr++;
    total++;
    if (nerr != 0) begin bad++; $display("FAIL flush_partial_data: %0d bad of %0d, required 0 bad of 512", nerr, wdq.size()); end
    total++;
    if (wrq.size() !== 1 || done_cnt != 1) begin
      bad++; $display("FAIL flush_partial_cmds: cmds=%0d done=%0d required 1/1", wrq.size(), done_cnt);
    end
  endtask

  task automatic test_flush_with_byte();
    int nerr = 0;
    do_reset();
    push_bytes(1, 1'b0, 8'h11);
    push_bytes(1, 1'b0, 8'h22);
    in_valid = 1'b1; in_data = 8'h33; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    wait_blk(1, "flush_with_byte");
    if (wdq.size() != 512) nerr++;
    else begin
      if (wdq[0] !== 8'h11 || wdq[1] !== 8'h22 || wdq[2] !== 8'h33) nerr++;
      for (int i = 3; i < 512; i++) if (wdq[i] !== 8'h00) nerr++;
    end
    total++;
    if (nerr != 0) begin bad++; $display("FAIL flush_with_byte_data: %0d bad of %0d, required 11 22 33 then 509x00", nerr, wdq.size()); end
  endtask

  task automatic test_flush_ignored();
    int t = 0;
    do_reset();
    pulse_flush();
    repeat (20) @(negedge clk);
    total++;
    if (wrq.size() != 0 || wr_stb !== 1'b0 || blk_cnt !== 32'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_empty: cmds=%0d wr_stb=%b cnt=%0d rdy=%b required 0/0/0/1", wrq.size(), wr_stb, blk_cnt, in_ready);
    end
    push_bytes(512, 1'b1, 8'h00);
    while (!wd_stb && t < 200) begin @(negedge clk); t++; end
    total++;
    if (wd_stb !== 1'b1) begin bad++; $display("FAIL flush_data_wait: wd_stb=%b required 1", wd_stb); end
    pulse_flush();
    wait_blk(1, "flush_in_data");
    repeat (30) @(negedge clk);
    total++;
    if (wrq.size() != 1 || blk_cnt !== 32'd1 || wr_stb !== 1'b0 || done_cnt != 1) begin
      bad++; $display("FAIL flush_in_data: cmds=%0d cnt=%0d wr_stb=%b done=%0d required 1/1/0/1", wrq.size(), blk_cnt, wr_stb, done_cnt);
    end
  endtask

  task automatic test_addr_wrap();
    do_reset();
    push_bytes(1024, 1'b1, 8'h00);
    wait_blk(2, "addr_wrap");
    total++;
    if (wwrq.size() != 2 || wwrq[0] !== 32'hFFFF_FFFF || wwrq[1] !== 32'h0000_0000) begin
      bad++; $display("FAIL wrap_addr: n=%0d a0=%h a1=%h required ffffffff then 00000000", wwrq.size(), wwrq[0], wwrq[1]);
    end
    total++;
    if (wrq.size() != 2 || wrq[0] !== 32'd0 || wrq[1] !== 32'd1 || wr_addr !== 32'd2 || w_wr_addr !== 32'd1) begin
      bad++; $display("FAIL wrap_base: a0=%h a1=%h addr=%h waddr=%h required 0/1/2/1", wrq[0], wrq[1], wr_addr, w_wr_addr);
    end
    total++;
    if (diff_cnt != 0) begin bad++; $display("FAIL twin_outputs: %0d cycles differ, required 0", diff_cnt); end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    int nerr = 0;
    do_reset();
    push_bytes(512, 1'b1, 8'h00);
    while (wdq.size() < 300 && t < 5000) begin @(negedge clk); t++; end
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, wr_stb, wd_stb, busy, blk_done} !== 5'b0 || wr_addr !== 32'd0 ||
        wd_data !== 8'h00 || blk_cnt !== 32'd0 || wdq.size() < 300) begin
      bad++; $display("FAIL reset_mid: rdy=%b wr=%b wd=%b busy=%b done=%b addr=%h data=%h cnt=%0d acked=%0d required zeros after 300",
                      in_ready, wr_stb, wd_stb, busy, blk_done, wr_addr, wd_data, blk_cnt, wdq.size());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr_mon();
    push_bytes(1, 1'b0, 8'h11);
    push_bytes(1, 1'b0, 8'h22);
    push_bytes(1, 1'b0, 8'h33);
    pulse_flush();
    wait_blk(1, "after_reset");
    if (wdq.size() != 512) nerr++;
    else begin
      if (wdq[0] !== 8'h11 || wdq[1] !== 8'h22 || wdq[2] !== 8'h33) nerr++;
      for (int i = 3; i < 512; i++) if (wdq[i] !== 8'h00) nerr++;
    end
    total++;
    if (nerr != 0 || wrq.size() != 1 || wrq[0] !== 32'd0) begin
      bad++; $display("FAIL after_reset_sector: bad=%0d cmds=%0d addr=%h required 0/1/00000000", nerr, wrq.size(), wrq[0]);
    end
  endtask

`ifdef SDW_PINGPONG_EN
  task automatic test_pingpong();
    int nerr = 0;
    do_reset();
    wd_dly = 1;
    push_bytes(1024, 1'b1, 8'h00);
    total++;
    if (stall_cnt != 0 || rdy_busy_cnt == 0) begin
      bad++; $display("FAIL pingpong_ready: stalls=%0d ready_busy=%0d required 0 and >0", stall_cnt, rdy_busy_cnt);
    end
    wait_blk(2, "pingpong");
    total++;
    if (wrq.size() != 2 || wrq[0] !== 32'd0 || wrq[1] !== 32'd1) begin
      bad++; $display("FAIL pingpong_addr: n=%0d a0=%h a1=%h required 0 then 1", wrq.size(), wrq[0], wrq[1]);
    end
    if (wdq.size() != 1024) nerr++;
    else for (int i = 0; i < 1024; i++) if (wdq[i] !== 8'(i)) nerr++;
    total++;
    if (nerr != 0) begin bad++; $display("FAIL pingpong_data: %0d bad of %0d, required 0 bad of 1024", nerr, wdq.size()); end
    wd_dly = 2;
  endtask
`endif

  initial begin
    test_reset();
    test_full_sector();
    test_flush_partial();
    test_flush_with_byte();
    test_flush_ignored();
    test_addr_wrap();
    test_reset_mid();
`ifdef SDW_PINGPONG_EN
    test_pingpong();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
